// File: rtl/seg_mux_driver.sv
// Time-multiplexed hex display driver: NUM_DIGITS digits on one shared active-low
// segment bus, with a blanking gap between slots and frame-synchronous digit updates.
module seg_mux_driver #(
  parameter int unsigned NUM_DIGITS   = 2,
  parameter int unsigned REFRESH_DIV  = 24000,
  parameter int unsigned BLANK_CYCLES = 480
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      load,
  input  logic [4*NUM_DIGITS-1:0]   digits_in,
  input  logic [NUM_DIGITS-1:0]     en_in,
  output logic                      pending,
  output logic [6:0]                seg,
  output logic [NUM_DIGITS-1:0]     an,
  output logic                      frame_done
);

  localparam int unsigned DW      = 4 * NUM_DIGITS;
  localparam int unsigned CNT_MAX = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
  localparam int unsigned CW      = $clog2((CNT_MAX > 2) ? CNT_MAX : 2);
  localparam int unsigned IW      = $clog2((NUM_DIGITS > 2) ? NUM_DIGITS : 2);

  localparam logic [CW-1:0] SHOW_LAST  = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK_CYCLES == 0) ? 0 : BLANK_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
  localparam logic [6:0]    SEG_OFF    = 7'h7F;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } state_t;

  state_t          state, state_n;
  logic [IW-1:0]   idx, idx_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [DW-1:0]   shadow_dig, shadow_dig_n;
  logic [NUM_DIGITS-1:0] shadow_en, shadow_en_n;
  logic [DW-1:0]   pend_dig, pend_dig_n;
  logic [NUM_DIGITS-1:0] pend_en, pend_en_n;
  logic            pending_n;
  logic [6:0]      seg_n;
  logic [NUM_DIGITS-1:0] an_n;
  logic            frame_done_n;
  logic            is_last;

  // Hex nibble to active-low {g..a} pattern.
  function automatic logic [6:0] decode(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  // State, counters, buffers and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= (BLANK_CYCLES == 0) ? ST_SHOW : ST_BLANK;
      idx        <= '0;
      cnt        <= '0;
      shadow_dig <= '0;
      shadow_en  <= '0;
      pend_dig   <= '0;
      pend_en    <= '0;
      pending    <= 1'b0;
      seg        <= SEG_OFF;
      an         <= '1;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      idx        <= idx_n;
      cnt        <= cnt_n;
      shadow_dig <= shadow_dig_n;
      shadow_en  <= shadow_en_n;
      pend_dig   <= pend_dig_n;
      pend_en    <= pend_en_n;
      pending    <= pending_n;
      seg        <= seg_n;
      an         <= an_n;
      frame_done <= frame_done_n;
    end
  end

  // Next state plus outputs derived from it, so outputs line up with the state they describe.
  always_comb begin
    state_n      = state;
    idx_n        = idx;
    cnt_n        = cnt;
    shadow_dig_n = shadow_dig;
    shadow_en_n  = shadow_en;
    pend_dig_n   = pend_dig;
    pend_en_n    = pend_en;
    pending_n    = pending;
    seg_n        = SEG_OFF;
    an_n         = '1;
    frame_done_n = 1'b0;
    is_last      = (state == ST_SHOW) && (idx == IDX_LAST) && (cnt == SHOW_LAST);

    case (state)
      ST_BLANK: begin
        if (cnt == BLANK_LAST) begin
          state_n = ST_SHOW;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      ST_SHOW: begin
        if (cnt == SHOW_LAST) begin
          cnt_n = '0;
          idx_n = (idx == IDX_LAST) ? IW'(0) : idx + IW'(1);
          if (BLANK_CYCLES != 0) state_n = ST_BLANK;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      default: state_n = ST_BLANK;
    endcase

    // A load in the boundary cycle is the newest write, so it beats the pending buffer.
    if (is_last) begin
      pending_n = 1'b0;
      if (load) begin
        shadow_dig_n = digits_in;
        shadow_en_n  = en_in;
      end else if (pending) begin
        shadow_dig_n = pend_dig;
        shadow_en_n  = pend_en;
      end
    end else if (load) begin
      pending_n  = 1'b1;
      pend_dig_n = digits_in;
      pend_en_n  = en_in;
    end

    if (state_n == ST_SHOW) begin
      for (int i = 0; i < int'(NUM_DIGITS); i++) begin
        if (idx_n == IW'(i) && shadow_en_n[i]) begin
          an_n[i] = 1'b0;
          seg_n   = decode(shadow_dig_n[4*i +: 4]);
        end
      end
    end

    frame_done_n = (state_n == ST_SHOW) && (idx_n == IDX_LAST) && (cnt_n == SHOW_LAST);
  end

endmodule

// File: tb/tb_seg_mux_driver.sv
// Self-checking bench for seg_mux_driver against a slot-position reference model.
`timescale 1ns/1ps
module tb_seg_mux_driver;

  localparam int N     = 3;
  localparam int R     = 4;
  localparam int B     = 1;
  localparam int SLOT  = R + B;
  localparam int FRAME = N * SLOT;

  logic          clk;
  logic          reset;
  logic          load;
  logic [4*N-1:0] digits_in;
  logic [N-1:0]  en_in;
  logic          pending;
  logic [6:0]    seg;
  logic [N-1:0]  an;
  logic          frame_done;

  int n_checks = 0;
  int n_fail   = 0;
  logic started = 1'b0;

  logic [6:0] seg_tab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  // Reference model: cycle position within the frame plus shadow/pending contents.
  int            m_t;
  logic [4*N-1:0] m_dig, m_bdig;
  logic [N-1:0]  m_en, m_ben;
  logic          m_pend;

  seg_mux_driver #(.NUM_DIGITS(N), .REFRESH_DIV(R), .BLANK_CYCLES(B)) dut (
    .clk(clk), .reset(reset), .load(load), .digits_in(digits_in), .en_in(en_in),
    .pending(pending), .seg(seg), .an(an), .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic lit();
    int p = m_t % FRAME;
    return ((p % SLOT) >= B) && m_en[p / SLOT];
  endfunction

  function automatic logic [N-1:0] exp_an();
    logic [N-1:0] r = '1;
    if (lit()) r[(m_t % FRAME) / SLOT] = 1'b0;
    return r;
  endfunction

  function automatic logic [6:0] exp_seg();
    logic [4*N-1:0] sh;
    sh = m_dig >> (4 * ((m_t % FRAME) / SLOT));
    return lit() ? seg_tab[sh[3:0]] : 7'h7F;
  endfunction

  function automatic logic exp_fd();
    return (m_t % FRAME) == FRAME - 1;
  endfunction

  // One clock: drive inputs, advance the model at the edge, return at the next negedge.
  task automatic tick(input logic ld, input logic [4*N-1:0] d, input logic [N-1:0] e);
    load = ld; digits_in = d; en_in = e;
    @(posedge clk);
    if (reset) begin
      m_t = 0; m_dig = '0; m_en = '0; m_pend = 1'b0; m_bdig = '0; m_ben = '0;
    end else begin
      if (m_t % FRAME == FRAME - 1) begin
        if (ld) begin m_dig = d; m_en = e; end
        else if (m_pend) begin m_dig = m_bdig; m_en = m_ben; end
        m_pend = 1'b0;
      end else if (ld) begin
        m_bdig = d; m_ben = e; m_pend = 1'b1;
      end
      m_t++;
    end
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic idle_until(input int p);
    for (int k = 0; k < FRAME && (m_t % FRAME) != p; k++) tick(1'b0, '0, '0);
  endtask

  // At most one anode low at any time.
  always @(negedge clk) begin
    if (started) begin
      n_checks++;
      if ($countones(~an) > 1) begin
        n_fail++;
        $display("FAIL an_onehot t=%0t got %b required at most one low", $time, an);
      end
    end
  end

  task automatic test_reset();
    reset = 1'b1;
    tick(1'b0, '0, '0);
    started = 1'b1;
    tick(1'b0, '0, '0);
    reset = 1'b0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      n_checks++;
      if (an !== 3'b111) begin n_fail++; $display("FAIL reset_an c=%0d got %b required 111", i, an); end
      n_checks++;
      if (seg !== 7'h7F) begin n_fail++; $display("FAIL reset_seg c=%0d got %h required 7f", i, seg); end
      n_checks++;
      if (frame_done !== (i == 14 || i == 29)) begin
        n_fail++; $display("FAIL reset_fd c=%0d got %b required %b", i, frame_done, (i == 14 || i == 29));
      end
      n_checks++;
      if (pending !== 1'b0) begin n_fail++; $display("FAIL reset_pend c=%0d got %b required 0", i, pending); end
      tick(1'b0, '0, '0);
    end
  endtask

  task automatic test_load_basic();
    idle_until(3);
    tick(1'b1, 12'h1A8, 3'b111);
    n_checks++;
    if (pending !== 1'b1) begin n_fail++; $display("FAIL load_pend_set got %b required 1", pending); end
    idle_until(0);
    n_checks++;
    if (pending !== 1'b0) begin n_fail++; $display("FAIL load_pend_clr got %b required 0", pending); end
    for (int i = 0; i < FRAME; i++) begin
      if (i == 2) begin
        n_checks++;
        if (an !== 3'b110 || seg !== 7'b0000000) begin
          n_fail++; $display("FAIL load_digit0 got an=%b seg=%b required an=110 seg=0000000", an, seg);
        end
      end
      n_checks++;
      if (an !== exp_an() || seg !== exp_seg() || frame_done !== exp_fd() || pending !== m_pend) begin
        n_fail++;
        $display("FAIL load_frame p=%0d got an=%b seg=%b fd=%b pend=%b required an=%b seg=%b fd=%b pend=%b",
                 m_t % FRAME, an, seg, frame_done, pending, exp_an(), exp_seg(), exp_fd(), m_pend);
      end
      tick(1'b0, '0, '0);
    end
  endtask

  task automatic test_midframe();
    idle_until(7);
    tick(1'b1, 12'h000, 3'b111);
    for (int i = 0; i < 2 * FRAME; i++) begin
      if ((m_t % FRAME) == 12) begin
        n_checks++;
        if (i < FRAME && (an !== 3'b011 || seg !== 7'b1111001)) begin
          n_fail++; $display("FAIL mid_keep got an=%b seg=%b required an=011 seg=1111001", an, seg);
        end
      end
      n_checks++;
      if (an !== exp_an() || seg !== exp_seg() || frame_done !== exp_fd() || pending !== m_pend) begin
        n_fail++;
        $display("FAIL mid_frame p=%0d got an=%b seg=%b fd=%b pend=%b required an=%b seg=%b fd=%b pend=%b",
                 m_t % FRAME, an, seg, frame_done, pending, exp_an(), exp_seg(), exp_fd(), m_pend);
      end
      tick(1'b0, '0, '0);
    end
  endtask

  task automatic test_enable();
    int last_fd;
    idle_until(2);
    tick(1'b1, 12'h005, 3'b011);
    idle_until(0);
    last_fd = -1;
    for (int i = 0; i < 2 * FRAME; i++) begin
      if ((m_t % FRAME) >= 11) begin
        n_checks++;
        if (an !== 3'b111) begin n_fail++; $display("FAIL en_blank p=%0d got %b required 111", m_t % FRAME, an); end
      end
      if ((m_t % FRAME) == 3) begin
        n_checks++;
        if (seg !== 7'b0010010) begin n_fail++; $display("FAIL en_digit0 got %b required 0010010", seg); end
      end
      if (frame_done === 1'b1) begin
        if (last_fd >= 0) begin
          n_checks++;
          if (i - last_fd != FRAME) begin n_fail++; $display("FAIL en_period got %0d required %0d", i - last_fd, FRAME); end
        end
        last_fd = i;
      end
      n_checks++;
      if (an !== exp_an() || seg !== exp_seg() || frame_done !== exp_fd()) begin
        n_fail++;
        $display("FAIL en_frame p=%0d got an=%b seg=%b fd=%b required an=%b seg=%b fd=%b",
                 m_t % FRAME, an, seg, frame_done, exp_an(), exp_seg(), exp_fd());
      end
      tick(1'b0, '0, '0);
    end
  endtask

  task automatic test_back_to_back();
    idle_until(0);
    tick(1'b1, 12'h111, 3'b111);
    tick(1'b0, '0, '0);
    tick(1'b1, 12'h222, 3'b111);
    idle_until(FRAME - 1);
    n_checks++;
    if (frame_done !== 1'b1) begin n_fail++; $display("FAIL b2b_fd got %b required 1", frame_done); end
    tick(1'b1, 12'h333, 3'b111);
    n_checks++;
    if (pending !== 1'b0) begin n_fail++; $display("FAIL b2b_pend got %b required 0", pending); end
    for (int i = 0; i < 2 * FRAME; i++) begin
      n_checks++;
      if (seg === 7'b0100100) begin n_fail++; $display("FAIL b2b_no222 got %b required not 0100100", seg); end
      if ((m_t % FRAME) == 2) begin
        n_checks++;
        if (an !== 3'b110 || seg !== 7'b0110000) begin
          n_fail++; $display("FAIL b2b_333 got an=%b seg=%b required an=110 seg=0110000", an, seg);
        end
      end
      n_checks++;
      if (an !== exp_an() || seg !== exp_seg() || frame_done !== exp_fd() || pending !== m_pend) begin
        n_fail++;
        $display("FAIL b2b_frame p=%0d got an=%b seg=%b fd=%b pend=%b required an=%b seg=%b fd=%b pend=%b",
                 m_t % FRAME, an, seg, frame_done, pending, exp_an(), exp_seg(), exp_fd(), m_pend);
      end
      tick(1'b0, '0, '0);
    end
  endtask

  task automatic test_reset_mid();
    idle_until(0);
    tick(1'b1, 12'h1A8, 3'b111);
    idle_until(7);
    n_checks++;
    if (pending !== 1'b1) begin n_fail++; $display("FAIL rmid_pend_before got %b required 1", pending); end
    reset = 1'b1;
    tick(1'b0, '0, '0);
    reset = 1'b0;
    n_checks++;
    if (an !== 3'b111 || seg !== 7'h7F || pending !== 1'b0 || frame_done !== 1'b0) begin
      n_fail++;
      $display("FAIL rmid_after got an=%b seg=%h pend=%b fd=%b required an=111 seg=7f pend=0 fd=0",
               an, seg, pending, frame_done);
    end
    for (int i = 0; i < 2 * FRAME; i++) begin
      n_checks++;
      if (an !== 3'b111 || seg !== 7'h7F || frame_done !== exp_fd()) begin
        n_fail++;
        $display("FAIL rmid_dark c=%0d got an=%b seg=%h fd=%b required an=111 seg=7f fd=%b",
                 i, an, seg, frame_done, exp_fd());
      end
      tick(1'b0, '0, '0);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 20 * FRAME; i++) begin
      n_checks++;
      if (an !== exp_an() || seg !== exp_seg() || frame_done !== exp_fd() || pending !== m_pend) begin
        n_fail++;
        $display("FAIL rand t=%0d got an=%b seg=%b fd=%b pend=%b required an=%b seg=%b fd=%b pend=%b",
                 m_t, an, seg, frame_done, pending, exp_an(), exp_seg(), exp_fd(), m_pend);
      end
      tick(($urandom_range(0, 5) == 0), 12'($urandom), 3'($urandom));
    end
  endtask

  initial begin
    reset = 1'b1; load = 1'b0; digits_in = '0; en_in = '0;
    m_t = 0; m_dig = '0; m_en = '0; m_pend = 1'b0; m_bdig = '0; m_ben = '0;
    @(negedge clk);
    test_reset();
    test_load_basic();
    test_midframe();
    test_enable();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
